// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the register bank and its dump engine.
package reg_bank_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultDepth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } dump_state_e;

  // Address width for a bank of the given depth; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_dump.sv
// Dump engine: walks every register index and streams each value out through a
// valid/ready handshake, pulsing dump_done once the last beat is taken.
module reg_bank_dump import reg_bank_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [WIDTH-1:0]  cap_data,   // reg[idx] with same-cycle write applied
  output logic [ADDR_W-1:0] idx,
  output logic              dump_valid,
  output logic              busy,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] idx_q;

  assign idx = idx_q;

  // State, index counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dump_start) begin
            state_q <= StLoad;
            idx_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StLoad: begin
          // Snapshot taken here; later writes to this index are not re-sent.
          dump_data  <= cap_data;
          dump_addr  <= idx_q;
          dump_valid <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx_q == LastIdx) begin
              state_q   <= StDone;
              busy      <= 1'b0;
              dump_done <= 1'b1;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= StLoad;
            end
          end
        end
        StDone: begin
          dump_done <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Register bank: one write port (acc or load source), two registered read ports
// with write-through bypass, and a dump engine that streams the whole bank out.
module reg_bank import reg_bank_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lacc,
  input  logic              ldm,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  acc,
  input  logic [WIDTH-1:0]  load,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              busy,
  output logic              dump_done
);

  // Storage covers the full address space; slots at or above DEPTH are never
  // written, so they stay zero and out-of-range reads need no extra mux.
  localparam int unsigned NumSlots = 2 ** ADDR_W;

  logic [WIDTH-1:0]  regs_q [NumSlots];
  logic              wen;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;
  logic [WIDTH-1:0]  dump_cap;
  logic [ADDR_W-1:0] dump_idx;

  // Write decode with acc priority, and bypassed read values for all readers.
  always_comb begin
    wen      = (lacc | ldm) && (32'(waddr) < DEPTH);
    wdata    = lacc ? acc : load;
    rd_a     = (wen && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
    rd_b     = (wen && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];
    dump_cap = (wen && (waddr == dump_idx)) ? wdata : regs_q[dump_idx];
  end

  // Storage update and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumSlots; i++) begin
        regs_q[i] <= '0;
      end
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (wen) begin
        regs_q[waddr] <= wdata;
      end
      rdata_a <= rd_a;
      rdata_b <= rd_b;
    end
  end

  reg_bank_dump #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .cap_data  (dump_cap),
    .idx       (dump_idx),
    .dump_valid(dump_valid),
    .busy      (busy),
    .dump_done (dump_done),
    .dump_addr (dump_addr),
    .dump_data (dump_data)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: a DEPTH=8 and a DEPTH=6 instance share all inputs; a
// memory-array model predicts read data and directed sequences check dumps.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lacc = 1'b0;
  logic        ldm = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] acc = '0;
  logic [15:0] load = '0;
  logic [2:0]  raddr_a = '0;
  logic [2:0]  raddr_b = '0;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b0;

  logic [15:0] rda8, rdb8, dd8, rda6, rdb6, dd6;
  logic [2:0]  da8, da6;
  logic        dv8, busy8, done8, dv6, busy6, done6;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(16), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .lacc(lacc), .ldm(ldm), .waddr(waddr), .acc(acc), .load(load),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda8), .rdata_b(rdb8),
    .dump_start(dump_start), .dump_valid(dv8), .dump_ready(dump_ready), .dump_addr(da8),
    .dump_data(dd8), .busy(busy8), .dump_done(done8)
  );

  reg_bank #(.WIDTH(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .lacc(lacc), .ldm(ldm), .waddr(waddr), .acc(acc), .load(load),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda6), .rdata_b(rdb6),
    .dump_start(dump_start), .dump_valid(dv6), .dump_ready(dump_ready), .dump_addr(da6),
    .dump_data(dd6), .busy(busy6), .dump_done(done6)
  );

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_done8 = 0, n_done6 = 0;
  int done_cyc8 = -1, done_cyc6 = -1;

  logic [15:0] m8 [8];
  logic [15:0] m6 [6];
  logic [2:0]  b8_addr [$];
  logic [15:0] b8_data [$];
  logic [2:0]  b6_addr [$];
  logic [15:0] b6_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_dump_log();
    b8_addr.delete(); b8_data.delete(); b6_addr.delete(); b6_data.delete();
    n_done8 = 0; n_done6 = 0; done_cyc8 = -1; done_cyc6 = -1;
  endtask

  // One clock: log accepted beats, advance, update the model, compare reads.
  task automatic cycle();
    logic        hold8, hold6;
    logic [2:0]  ha8, ha6;
    logic [15:0] hd8, hd6, wd, ea, eb;
    hold8 = dv8 && !dump_ready && !rst;
    hold6 = dv6 && !dump_ready && !rst;
    ha8 = da8; hd8 = dd8; ha6 = da6; hd6 = dd6;
    if (dv8 && dump_ready) begin b8_addr.push_back(da8); b8_data.push_back(dd8); end
    if (dv6 && dump_ready) begin b6_addr.push_back(da6); b6_data.push_back(dd6); end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      foreach (m8[i]) m8[i] = '0;
      foreach (m6[i]) m6[i] = '0;
    end else if (lacc || ldm) begin
      wd = lacc ? acc : load;
      m8[waddr] = wd;
      if (waddr < 3'd6) m6[waddr] = wd;
    end
    check("rdata_a8", 32'(rda8), 32'(m8[raddr_a]));
    check("rdata_b8", 32'(rdb8), 32'(m8[raddr_b]));
    ea = (raddr_a < 3'd6) ? m6[raddr_a] : 16'h0;
    eb = (raddr_b < 3'd6) ? m6[raddr_b] : 16'h0;
    check("rdata_a6", 32'(rda6), 32'(ea));
    check("rdata_b6", 32'(rdb6), 32'(eb));
    if (hold8) begin
      check("stall_valid8", 32'(dv8), 32'(1));
      check("stall_addr8", 32'(da8), 32'(ha8));
      check("stall_data8", 32'(dd8), 32'(hd8));
    end
    if (hold6) begin
      check("stall_valid6", 32'(dv6), 32'(1));
      check("stall_addr6", 32'(da6), 32'(ha6));
      check("stall_data6", 32'(dd6), 32'(hd6));
    end
    if (done8) begin n_done8++; done_cyc8 = cyc - start_cyc; end
    if (done6) begin n_done6++; done_cyc6 = cyc - start_cyc; end
  endtask

  task automatic check_beats(input string tag, input int n_exp);
    check({tag, "_count8"}, 32'(b8_addr.size()), 32'(n_exp));
    check({tag, "_count6"}, 32'(b6_addr.size()), 32'(n_exp > 6 ? 6 : n_exp));
    for (int i = 0; i < b8_addr.size(); i++) begin
      check($sformatf("%s_addr8[%0d]", tag, i), 32'(b8_addr[i]), 32'(i));
      check($sformatf("%s_data8[%0d]", tag, i), 32'(b8_data[i]), 32'(16'h0100 + i));
    end
    for (int i = 0; i < b6_addr.size(); i++) begin
      check($sformatf("%s_addr6[%0d]", tag, i), 32'(b6_addr[i]), 32'(i));
      check($sformatf("%s_data6[%0d]", tag, i), 32'(b6_data[i]), 32'(16'h0100 + i));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid8"}, 32'(dv8), 32'(0));
    check({tag, "_busy8"}, 32'(busy8), 32'(0));
    check({tag, "_done8"}, 32'(done8), 32'(0));
    check({tag, "_daddr8"}, 32'(da8), 32'(0));
    check({tag, "_ddata8"}, 32'(dd8), 32'(0));
    check({tag, "_valid6"}, 32'(dv6), 32'(0));
    check({tag, "_busy6"}, 32'(busy6), 32'(0));
    check({tag, "_ddata6"}, 32'(dd6), 32'(0));
  endtask

  initial begin
    bit stalled;
    int k;

    // Reset.
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    check_idle_zero("reset");
    check("reset_rdata_a8", 32'(rda8), 32'(0));

    // acc wins over load when both are requested.
    lacc = 1'b1; ldm = 1'b1; waddr = 3'd3; acc = 16'h1234; load = 16'hBEEF;
    cycle();
    lacc = 1'b0; ldm = 1'b0; raddr_a = 3'd3;
    cycle();
    check("prio_rdata_a8", 32'(rda8), 32'h1234);

    // Write-through bypass on port B.
    ldm = 1'b1; waddr = 3'd5; load = 16'h00AA; raddr_b = 3'd5;
    cycle();
    ldm = 1'b0;
    check("bypass_rdata_b8", 32'(rdb8), 32'h00AA);
    check("bypass_rdata_b6", 32'(rdb6), 32'h00AA);

    // Address 7 is out of range only for the 6-deep bank.
    lacc = 1'b1; waddr = 3'd7; acc = 16'h5555; raddr_a = 3'd7;
    cycle();
    lacc = 1'b0;
    cycle();
    check("oor_rdata_a8", 32'(rda8), 32'h5555);
    check("oor_rdata_a6", 32'(rda6), 32'h0);

    // Random writes and reads against the model.
    for (int i = 0; i < 200; i++) begin
      lacc = ($urandom_range(0, 3) == 0);
      ldm = ($urandom_range(0, 2) == 0);
      waddr = 3'($urandom_range(0, 7));
      acc = 16'($urandom);
      load = 16'($urandom);
      raddr_a = 3'($urandom_range(0, 7));
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      cycle();
    end
    lacc = 1'b0; ldm = 1'b0;

    // Full dump with ready held high.
    for (int i = 0; i < 8; i++) begin
      lacc = 1'b1; waddr = 3'(i); acc = 16'(16'h0100 + i);
      cycle();
    end
    lacc = 1'b0;
    dump_ready = 1'b1;
    clear_dump_log();
    dump_start = 1'b1; start_cyc = cyc;
    cycle();
    dump_start = 1'b0;
    check("dump1_busy8", 32'(busy8), 32'(1));
    check("dump1_load_valid8", 32'(dv8), 32'(0));
    repeat (30) cycle();
    check_beats("dump1", 8);
    check("dump1_ndone8", 32'(n_done8), 32'(1));
    check("dump1_donecyc8", 32'(done_cyc8), 32'(17));
    check("dump1_ndone6", 32'(n_done6), 32'(1));
    check("dump1_donecyc6", 32'(done_cyc6), 32'(13));

    // Stall on beat 2 with a write to reg 2 and a stray dump_start.
    clear_dump_log();
    stalled = 1'b0;
    dump_start = 1'b1; start_cyc = cyc;
    cycle();
    dump_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!stalled && dv8 && (da8 == 3'd2)) begin
        stalled = 1'b1;
        dump_ready = 1'b0;
        lacc = 1'b1; waddr = 3'd2; acc = 16'hFFFF; dump_start = 1'b1;
        cycle();
        lacc = 1'b0; dump_start = 1'b0;
        repeat (3) cycle();
        dump_ready = 1'b1;
      end else begin
        cycle();
      end
    end
    check("dump2_stalled", 32'(stalled), 32'(1));
    check_beats("dump2", 8);
    check("dump2_ndone8", 32'(n_done8), 32'(1));
    check("dump2_donecyc8", 32'(done_cyc8), 32'(21));
    check("dump2_donecyc6", 32'(done_cyc6), 32'(17));
    raddr_a = 3'd2;
    cycle();
    check("dump2_reg2_8", 32'(rda8), 32'hFFFF);

    // Reset part-way through a dump.
    clear_dump_log();
    dump_start = 1'b1; start_cyc = cyc;
    cycle();
    dump_start = 1'b0;
    k = 0;
    while (b8_addr.size() < 5 && k < 40) begin
      cycle();
      k++;
    end
    check("abort_beats8", 32'(b8_addr.size()), 32'(5));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_idle_zero("abort");
    repeat (20) cycle();
    check("abort_ndone8", 32'(n_done8), 32'(0));
    check("abort_ndone6", 32'(n_done6), 32'(0));
    check("abort_nbeats8", 32'(b8_addr.size()), 32'(5));
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(7 - i);
      cycle();
      check($sformatf("abort_read8[%0d]", i), 32'(rda8), 32'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 16: data width of every register and port.
REQ-002 Parameter DEPTH, default 8: number of registers, range 2..256; ADDR_W = max(1, clog2(DEPTH)) is a derived localparam.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 lacc  input  1  write request, source acc.
REQ-006 ldm  input  1  write request, source load.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 acc  input  WIDTH  accumulator write data.
REQ-009 load  input  WIDTH  memory-load write data.
REQ-010 raddr_a, raddr_b  input  ADDR_W each  read addresses, ports A and B.
REQ-011 rdata_a, rdata_b  output  WIDTH each  registered read data.
REQ-012 dump_start  input  1  one-cycle request to stream out all registers.
REQ-013 dump_valid  output  1  dump beat present.
REQ-014 dump_ready  input  1  consumer accepts the beat.
REQ-015 dump_addr  output  ADDR_W  index of the beat presented.
REQ-016 dump_data  output  WIDTH  value of the beat presented.
REQ-017 busy  output  1  dump in progress (states LOAD or SEND).
REQ-018 dump_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-019 Write: lacc=1 writes acc to reg[waddr]; else ldm=1 writes load to reg[waddr]; lacc has priority when both are high.
REQ-020 A write with waddr >= DEPTH is ignored; a read with raddr >= DEPTH returns 0.
REQ-021 Read latency is 1 cycle: rdata_x in cycle n+1 equals reg[raddr_x] sampled in cycle n.
REQ-022 Write-through bypass: if a write targets raddr_x in cycle n, rdata_x in cycle n+1 is the new data.
REQ-023 Dump FSM states: IDLE, LOAD, SEND, DONE.
REQ-024 IDLE: dump_start=1 -> LOAD with index 0; otherwise stay in IDLE.
REQ-025 LOAD: capture reg[index] (with REQ-022 bypass applied) into dump_data and index into dump_addr -> SEND.
REQ-026 SEND: dump_valid=1; dump_data and dump_addr stay stable until dump_ready=1.
REQ-027 SEND with dump_ready=1: if index = DEPTH-1 -> DONE, otherwise index+1 -> LOAD.
REQ-028 DONE: dump_done=1 for exactly one cycle -> IDLE.
REQ-029 dump_start is ignored outside IDLE.
REQ-030 Writes are never blocked; a write to an index that has already been captured is not re-sent.
REQ-031 A full dump with dump_ready held high takes 2*DEPTH+1 cycles from dump_start to dump_done.

Reset
REQ-032 rst=1 at a clock edge: every register = 0, rdata_a = rdata_b = 0, dump_data = 0, dump_addr = 0, dump_valid = busy = dump_done = 0, FSM = IDLE.
REQ-033 rst has priority over writes and dump_start in the same cycle.
REQ-034 rst during a dump aborts it; dump_done is not pulsed.

Structure
REQ-035 Package reg_bank_pkg holds the dump-state enum and the WIDTH/DEPTH default constants.
REQ-036 The dump FSM is sub-module reg_bank_dump, with the index counter and handshake; storage and read ports are in reg_bank.

Verification
REQ-037 WIDTH=16, DEPTH=8: lacc=1, ldm=1, waddr=3, acc=0x1234, load=0xBEEF, then read raddr_a=3 -> rdata_a=0x1234 one cycle later.
REQ-038 Same cycle: ldm=1, waddr=5, load=0x00AA, raddr_b=5 -> rdata_b=0x00AA next cycle (bypass).
REQ-039 reg[i]=0x0100+i, dump_start with dump_ready=1 -> 8 beats with addr 0..7, data 0x0100..0x0107, dump_done at cycle 17.
REQ-040 dump_ready=0 for 4 cycles on beat 2, with a write of 0xFFFF to reg 2 during the stall -> beat 2 stays 0x0102; dump_start during busy is ignored.
REQ-041 rst=1 mid-dump after beat 4 -> all outputs 0 next cycle, no dump_done; a following read of any register -> 0.
REQ-042 DEPTH=6: write waddr=7 ignored; read raddr=7 -> 0; dump gives 6 beats and dump_done at cycle 13.
